data_memory_io: RTL and testbench
=================================

DATA_MEMORY_IO -- requirements
Module: data_memory_io

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL: mem_wr  input  1  store strobe from core; write occurs at next rising clk.
REQ-004 SHALL: mem_rd  input  1  load strobe from core.
REQ-005 SHALL: data_mem_address  input  6  word address from core ALU.
REQ-006 SHALL: reg_Data_2  input  16  store data from core.
REQ-007 SHALL: mem_Data_in  output  16  load data to core, combinational from address.
REQ-008 SHALL: gpio_in  input  16  asynchronous external inputs.
REQ-009 SHALL: gpio_out  output  16  registered output port.
REQ-010 SHALL: irq  output  1  timer match interrupt, level.

Function
REQ-011 SHALL: address map: 0x00-0x37 RAM (56x16); 0x38 GPIO_OUT rw; 0x39 GPIO_IN ro; 0x3A TIMER_CNT rw; 0x3B TIMER_CMP rw; 0x3C TIMER_CTRL rw; 0x3D STATUS; 0x3E-0x3F reserved.
REQ-012 SHALL: mem_Data_in = selected word when mem_rd=1, else 16'h0000; zero-latency, same-cycle read.
REQ-013 SHALL: mem_wr=1 at rising clk writes reg_Data_2 to addressed RAM word or rw register.
REQ-014 SHALL: mem_rd and mem_wr both high: read returns pre-write value; write lands at clock edge.
REQ-015 SHALL: writes to GPIO_IN, reserved addresses ignored; reserved reads return 0.
REQ-016 SHALL: GPIO_IN = gpio_in through 2-flop synchronizer; 2-cycle latency.
REQ-017 SHALL: TIMER_CTRL bits: [0] enable, [1] auto-clear on match, [2] irq enable; bits [15:3] read 0.
REQ-018 SHALL: enable=1: TIMER_CNT increments by 1 per cycle, 16-bit wrap 0xFFFF->0x0000.
REQ-019 SHALL: enable=1 and TIMER_CNT==TIMER_CMP: STATUS[0] set at next edge; auto-clear=1 loads TIMER_CNT with 0 at that edge instead of incrementing.
REQ-020 SHALL: CPU write to TIMER_CNT overrides increment/auto-clear in the same cycle.
REQ-021 SHALL: STATUS[0] write-1-to-clear; clear and set in the same cycle -> set wins; STATUS[15:1] read 0.
REQ-022 SHALL: irq = STATUS[0] & TIMER_CTRL[2], combinational from registers.
REQ-023 SHALL: enable=0: TIMER_CNT holds; no match detection.

Reset
REQ-024 SHALL: rst clears gpio_out, synchronizer flops, TIMER_CNT, TIMER_CTRL, STATUS to 0; TIMER_CMP to 16'hFFFF; irq=0.
REQ-025 SHALL: RAM contents not reset; undefined until written.
REQ-026 SHALL: rst asserted mid-count stops timer immediately; counting resumes only after enable is rewritten.
REQ-027 SHALL: mem_Data_in remain combinational during reset (RAM readable, registers read reset values).

Configuration
REQ-028 SHALL: macro DMEM_TIMER_EN defined: timer, STATUS, irq implemented per REQ-017..023.
REQ-029 SHALL: DMEM_TIMER_EN undefined: 0x3A-0x3D behave as reserved (read 0, writes ignored), irq tied 0, no timer flops.

Verification
REQ-030 SHALL: write 0xBEEF to 0x05, next cycle read 0x05 -> mem_Data_in=0xBEEF; mem_rd=0 -> 0x0000.
REQ-031 SHALL: simultaneous rd+wr 0x1234 to 0x05 holding 0xBEEF -> same cycle reads 0xBEEF; next cycle reads 0x1234.
REQ-032 SHALL: gpio_in=0x00A5 -> read 0x39 returns 0x00A5 on the 2nd edge, not 1st; write 0x0F0F to 0x38 -> gpio_out=0x0F0F after edge.
REQ-033 SHALL: CMP=5, CTRL=0x7 -> STATUS[0]=1 and irq=1 one cycle after CNT==5, CNT=0 then; write 0x1 to 0x3D -> irq=0.
REQ-034 SHALL: CNT=0xFFFF, CMP=0x0010, CTRL=0x1 -> CNT reads 0x0000 next cycle; CPU write 0x0100 to CNT same cycle as increment -> 0x0100.
REQ-035 SHALL: build without DMEM_TIMER_EN, write 0xFFFF to 0x3A-0x3D -> all read 0, irq stays 0.

Source files
------------

// File: rtl/data_memory_io.sv
// Memory-mapped data memory: 56x16 RAM, GPIO ports and an optional compare timer.
// Define DMEM_TIMER_EN to build the timer, STATUS register and irq output.
module data_memory_io (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_wr,
    input  logic        mem_rd,
    input  logic [5:0]  data_mem_address,
    input  logic [15:0] reg_Data_2,
    output logic [15:0] mem_Data_in,
    input  logic [15:0] gpio_in,
    output logic [15:0] gpio_out,
    output logic        irq
);

    localparam logic [5:0] RAM_WORDS     = 6'd56;
    localparam logic [5:0] ADDR_GPIO_OUT = 6'h38;
    localparam logic [5:0] ADDR_GPIO_IN  = 6'h39;
`ifdef DMEM_TIMER_EN
    localparam logic [5:0] ADDR_TMR_CNT  = 6'h3A;
    localparam logic [5:0] ADDR_TMR_CMP  = 6'h3B;
    localparam logic [5:0] ADDR_TMR_CTRL = 6'h3C;
    localparam logic [5:0] ADDR_STATUS   = 6'h3D;
`endif

    logic [15:0] ram_q [0:55];
    logic        ram_we;
    logic [15:0] gpio_out_d, gpio_out_q;
    logic [15:0] gpio_s1_d, gpio_s1_q;
    logic [15:0] gpio_s2_d, gpio_s2_q;
    logic [15:0] rd_word;

    // RAM has no reset; its contents persist across rst.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_q[data_mem_address] <= reg_Data_2;
        end
    end

    always_comb begin
        ram_we     = mem_wr && (data_mem_address < RAM_WORDS);
        gpio_out_d = gpio_out_q;
        if (mem_wr && (data_mem_address == ADDR_GPIO_OUT)) begin
            gpio_out_d = reg_Data_2;
        end
        gpio_s1_d = gpio_in;
        gpio_s2_d = gpio_s1_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gpio_out_q <= 16'h0000;
            gpio_s1_q  <= 16'h0000;
            gpio_s2_q  <= 16'h0000;
        end else begin
            gpio_out_q <= gpio_out_d;
            gpio_s1_q  <= gpio_s1_d;
            gpio_s2_q  <= gpio_s2_d;
        end
    end

    assign gpio_out = gpio_out_q;

`ifdef DMEM_TIMER_EN
    logic [15:0] cnt_d, cnt_q;
    logic [15:0] cmp_d, cmp_q;
    logic [2:0]  ctrl_d, ctrl_q;
    logic        status_d, status_q;
    logic        match;

    // CPU write to the counter takes priority over increment/auto-clear;
    // a match setting STATUS beats a same-cycle write-1-to-clear.
    always_comb begin
        match    = ctrl_q[0] && (cnt_q == cmp_q);
        cnt_d    = cnt_q;
        cmp_d    = cmp_q;
        ctrl_d   = ctrl_q;
        status_d = status_q;
        if (ctrl_q[0]) begin
            cnt_d = (match && ctrl_q[1]) ? 16'h0000 : cnt_q + 16'h0001;
        end
        if (mem_wr && (data_mem_address == ADDR_TMR_CNT)) begin
            cnt_d = reg_Data_2;
        end
        if (mem_wr && (data_mem_address == ADDR_TMR_CMP)) begin
            cmp_d = reg_Data_2;
        end
        if (mem_wr && (data_mem_address == ADDR_TMR_CTRL)) begin
            ctrl_d = reg_Data_2[2:0];
        end
        if (mem_wr && (data_mem_address == ADDR_STATUS) && reg_Data_2[0]) begin
            status_d = 1'b0;
        end
        if (match) begin
            status_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= 16'h0000;
            cmp_q    <= 16'hFFFF;
            ctrl_q   <= 3'b000;
            status_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            cmp_q    <= cmp_d;
            ctrl_q   <= ctrl_d;
            status_q <= status_d;
        end
    end

    assign irq = status_q & ctrl_q[2];
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rd_word = 16'h0000;
        if (data_mem_address < RAM_WORDS) begin
            rd_word = ram_q[data_mem_address];
        end else begin
            case (data_mem_address)
                ADDR_GPIO_OUT: rd_word = gpio_out_q;
                ADDR_GPIO_IN:  rd_word = gpio_s2_q;
`ifdef DMEM_TIMER_EN
                ADDR_TMR_CNT:  rd_word = cnt_q;
                ADDR_TMR_CMP:  rd_word = cmp_q;
                ADDR_TMR_CTRL: rd_word = {13'h0000, ctrl_q};
                ADDR_STATUS:   rd_word = {15'h0000, status_q};
`endif
                default:       rd_word = 16'h0000;
            endcase
        end
        mem_Data_in = mem_rd ? rd_word : 16'h0000;
    end

endmodule

// File: tb/tb_data_memory_io.sv
// Self-checking bench for data_memory_io: memory-map model plus directed literal checks.
// Timer checks are compiled in when DMEM_TIMER_EN is defined, reserved-map checks otherwise.
module tb_data_memory_io;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_wr;
    logic        mem_rd;
    logic [5:0]  addr;
    logic [15:0] wdata;
    logic [15:0] gpio_in;
    logic [15:0] mem_Data_in;
    logic [15:0] gpio_out;
    logic        irq;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    data_memory_io dut (
        .clk              (clk),
        .rst              (rst),
        .mem_wr           (mem_wr),
        .mem_rd           (mem_rd),
        .data_mem_address (addr),
        .reg_Data_2       (wdata),
        .mem_Data_in      (mem_Data_in),
        .gpio_in          (gpio_in),
        .gpio_out         (gpio_out),
        .irq              (irq)
    );

    // Behavioural model of the memory map
    logic [15:0] m_ram [56];
    bit          m_vld [56];
    logic [15:0] m_gout;
    logic [15:0] m_gpio_prev1;
    logic [15:0] m_gpio_prev2;
    logic [15:0] m_cnt;
    logic [15:0] m_cmp;
    logic [2:0]  m_ctrl;
    bit          m_stat;
    bit          m_hit;
    logic [15:0] m_cnt_next;

    initial begin
        for (int i = 0; i < 56; i++) m_vld[i] = 1'b0;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_gout       = 16'h0000;
            m_gpio_prev1 = 16'h0000;
            m_gpio_prev2 = 16'h0000;
            m_cnt        = 16'h0000;
            m_cmp        = 16'hFFFF;
            m_ctrl       = 3'b000;
            m_stat       = 1'b0;
        end else begin
            m_hit      = (m_ctrl[0] == 1'b1) && (m_cnt == m_cmp);
            m_cnt_next = m_cnt;
            if (m_ctrl[0]) m_cnt_next = (m_hit && m_ctrl[1]) ? 16'h0000 : m_cnt + 16'd1;
            if (mem_wr) begin
                if (addr < 6'd56) begin
                    m_ram[addr] = wdata;
                    m_vld[addr] = 1'b1;
                end
                if (addr == 6'h38) m_gout = wdata;
                if (addr == 6'h3A) m_cnt_next = wdata;
                if (addr == 6'h3B) m_cmp = wdata;
                if (addr == 6'h3C) m_ctrl = wdata[2:0];
                if (addr == 6'h3D && wdata[0]) m_stat = 1'b0;
            end
            if (m_hit) m_stat = 1'b1;
            m_cnt = m_cnt_next;
            m_gpio_prev2 = m_gpio_prev1;
            m_gpio_prev1 = gpio_in;
        end
    end

    function automatic logic [15:0] m_read(input logic [5:0] a);
        if (a < 6'd56) return m_ram[a];
        case (a)
            6'h38: return m_gout;
            6'h39: return m_gpio_prev2;
`ifdef DMEM_TIMER_EN
            6'h3A: return m_cnt;
            6'h3B: return m_cmp;
            6'h3C: return {13'h0, m_ctrl};
            6'h3D: return {15'h0, m_stat};
`endif
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic m_irq();
`ifdef DMEM_TIMER_EN
        return m_stat & m_ctrl[2];
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!(mem_rd && addr < 6'd56 && !m_vld[addr]))
            check("model_rd", mem_Data_in, mem_rd ? m_read(addr) : 16'h0000);
        check("model_gpio_out", gpio_out, m_gout);
        check("model_irq", {15'h0, irq}, {15'h0, m_irq()});
    end

    task automatic put(input logic w, input logic r, input logic [5:0] a, input logic [15:0] d);
        #2;
        mem_wr = w;
        mem_rd = r;
        addr   = a;
        wdata  = d;
        #1;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wr(input logic [5:0] a, input logic [15:0] d);
        put(1'b1, 1'b0, a, d);
        tick();
    endtask

    task automatic rd_chk(input string name, input logic [5:0] a, input logic [15:0] exp);
        put(1'b0, 1'b1, a, 16'h0000);
        check(name, mem_Data_in, exp);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        rst = 1'b1; mem_wr = 1'b0; mem_rd = 1'b1; addr = 6'h38; wdata = 16'h0; gpio_in = 16'h0;
        tick(); tick();
        check("rst_gpio_out", gpio_out, 16'h0000);
        check("rst_irq", {15'h0, irq}, 16'h0000);
        check("rst_rd_gpio_out", mem_Data_in, 16'h0000);
`ifdef DMEM_TIMER_EN
        put(1'b0, 1'b1, 6'h3B, 16'h0);
        check("rst_rd_cmp", mem_Data_in, 16'hFFFF);
        tick();
`endif
        #2 rst = 1'b0;
        tick();

        // RAM write/read, rd gating, read-during-write
        wr(6'h05, 16'hBEEF);
        rd_chk("ram_rd_beef", 6'h05, 16'hBEEF);
        put(1'b0, 1'b0, 6'h05, 16'h0);
        check("ram_rd_gated", mem_Data_in, 16'h0000);
        tick();
        put(1'b1, 1'b1, 6'h05, 16'h1234);
        check("rdwr_pre_value", mem_Data_in, 16'hBEEF);
        tick();
        check("rdwr_post_value", mem_Data_in, 16'h1234);
        wr(6'h00, 16'hA001);
        wr(6'h37, 16'h5A37);
        rd_chk("ram_rd_lo", 6'h00, 16'hA001);
        rd_chk("ram_rd_hi", 6'h37, 16'h5A37);

        // GPIO input synchronizer latency
        put(1'b0, 1'b1, 6'h39, 16'h0);
        gpio_in = 16'h00A5;
        check("gpio_in_edge0", mem_Data_in, 16'h0000);
        tick();
        check("gpio_in_edge1", mem_Data_in, 16'h0000);
        tick();
        check("gpio_in_edge2", mem_Data_in, 16'h00A5);

        // GPIO output register
        put(1'b1, 1'b0, 6'h38, 16'h0F0F);
        check("gpio_out_pre", gpio_out, 16'h0000);
        tick();
        check("gpio_out_post", gpio_out, 16'h0F0F);
        rd_chk("gpio_out_rd", 6'h38, 16'h0F0F);

        // Read-only and reserved addresses
        wr(6'h39, 16'hFFFF);
        rd_chk("gpio_in_ro", 6'h39, 16'h00A5);
        wr(6'h3E, 16'hFFFF);
        rd_chk("resv_3e", 6'h3E, 16'h0000);
        rd_chk("resv_3f", 6'h3F, 16'h0000);

`ifdef DMEM_TIMER_EN
        // Compare match with auto-clear and interrupt
        wr(6'h3B, 16'd5);
        wr(6'h3A, 16'd0);
        wr(6'h3C, 16'h0007);
        put(1'b0, 1'b1, 6'h3A, 16'h0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (mem_Data_in == 16'd5) found = 1'b1;
            else tick();
        end
        check("cnt_reaches_5", {15'h0, found}, 16'h0001);
        put(1'b0, 1'b1, 6'h3D, 16'h0);
        check("status_before_match_edge", mem_Data_in, 16'h0000);
        tick();
        check("status_set", mem_Data_in, 16'h0001);
        check("irq_set", {15'h0, irq}, 16'h0001);
        put(1'b0, 1'b1, 6'h3A, 16'h0);
        check("cnt_autocleared", mem_Data_in, 16'h0000);
        tick();
        wr(6'h3C, 16'h0004);
        wr(6'h3D, 16'h0001);
        check("irq_cleared", {15'h0, irq}, 16'h0000);
        rd_chk("status_cleared", 6'h3D, 16'h0000);
        wr(6'h3C, 16'hFFFC);
        rd_chk("ctrl_upper_zero", 6'h3C, 16'h0004);

        // Wrap and CPU write priority
        wr(6'h3C, 16'h0000);
        wr(6'h3B, 16'h0010);
        wr(6'h3A, 16'hFFFF);
        wr(6'h3C, 16'h0001);
        put(1'b0, 1'b1, 6'h3A, 16'h0);
        check("cnt_ffff", mem_Data_in, 16'hFFFF);
        tick();
        check("cnt_wrap", mem_Data_in, 16'h0000);
        put(1'b1, 1'b1, 6'h3A, 16'h0100);
        tick();
        check("cnt_cpu_override", mem_Data_in, 16'h0100);
        put(1'b0, 1'b1, 6'h3A, 16'h0);
        tick();
        check("cnt_increment", mem_Data_in, 16'h0101);

        // Reset while counting
        #2 rst = 1'b1;
        #1;
        check("rst_mid_cnt", mem_Data_in, 16'h0000);
        check("rst_mid_gpio_out", gpio_out, 16'h0000);
        tick();
        #2 rst = 1'b0;
        tick(); tick(); tick();
        rd_chk("cnt_stopped_after_rst", 6'h3A, 16'h0000);
        rd_chk("cmp_after_rst", 6'h3B, 16'hFFFF);
`else
        // Timer addresses behave as reserved
        wr(6'h3A, 16'hFFFF);
        wr(6'h3B, 16'hFFFF);
        wr(6'h3C, 16'hFFFF);
        wr(6'h3D, 16'hFFFF);
        rd_chk("notmr_3a", 6'h3A, 16'h0000);
        rd_chk("notmr_3b", 6'h3B, 16'h0000);
        rd_chk("notmr_3c", 6'h3C, 16'h0000);
        rd_chk("notmr_3d", 6'h3D, 16'h0000);
        check("notmr_irq", {15'h0, irq}, 16'h0000);

        // Reset mid-run
        #2 rst = 1'b1;
        #1;
        check("rst_mid_gpio_out", gpio_out, 16'h0000);
        tick();
        #2 rst = 1'b0;
        tick();
`endif
        rd_chk("ram_kept_over_rst", 6'h05, 16'h1234);
        put(1'b0, 1'b0, 6'h00, 16'h0);
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
